// File: rtl/sdio_cmdseq.sv
// Command sequencer for the sdio_top Wishbone control port: writes argument and
// command, polls status until busy clears, reads the response word, returns it.
module sdio_cmdseq #(
    parameter logic [2:0]  ADDR_CMD  = 3'd0,
    parameter logic [2:0]  ADDR_ARG  = 3'd1,
    parameter logic [31:0] BUSY_MASK = 32'h0000_4000,
    parameter logic [31:0] ERR_MASK  = 32'h0000_8000,
    parameter int          LGPOLL    = 16,
    parameter int          POLL_GAP  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_ctl,
    input  logic [31:0] i_req_arg,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic [31:0] o_rsp_status,
    output logic        o_rsp_err,
    output logic        o_rsp_timeout,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic [2:0]  dbg_state
);
    // Handshakes: a request transfers on the edge where i_req_valid && o_req_ready;
    // a response transfers on the edge where o_rsp_valid && i_rsp_ready, and its
    // payload is held stable from the rise of o_rsp_valid until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ARG  = 3'd1,
        WR_CMD  = 3'd2,
        GAP     = 3'd3,
        RD_STAT = 3'd4,
        RD_RSP  = 3'd5,
        RESP    = 3'd6
    } state_t;

    localparam int GW = $clog2(POLL_GAP + 1);

    state_t            state, state_nx;
    logic [GW-1:0]     gap_cnt;
    logic [LGPOLL-1:0] poll_cnt;
    logic [31:0]       ctl_q;
    logic              accept, bus_done, stat_busy, poll_last, gap_done, launch;

    assign accept    = i_req_valid && o_req_ready;
    assign bus_done  = o_wb_cyc && i_wb_ack;
    assign stat_busy = (i_wb_data & BUSY_MASK) != '0;
    assign poll_last = (poll_cnt == '1);
    assign gap_done  = (gap_cnt == GW'(POLL_GAP - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WR_ARG;
            WR_ARG:  if (bus_done) state_nx = WR_CMD;
            WR_CMD:  if (bus_done) state_nx = GAP;
            GAP:     if (gap_done) state_nx = RD_STAT;
            RD_STAT: begin
                if (bus_done) begin
                    if (!stat_busy)     state_nx = RD_RSP;
                    else if (poll_last) state_nx = RESP;
                    else                state_nx = GAP;
                end
            end
            RD_RSP:  if (bus_done) state_nx = RESP;
            RESP:    if (o_rsp_valid && i_rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE);
        o_wb_sel    = 4'hf;
        dbg_state   = state;
    end

    // Bus ops are launched on the edge that enters a bus state, so back-to-back
    // ops keep cyc high across the ack/launch edge.
    assign launch = (state_nx != state) &&
                    (state_nx == WR_ARG || state_nx == WR_CMD ||
                     state_nx == RD_STAT || state_nx == RD_RSP);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_addr     <= 3'd0;
            o_wb_data     <= 32'h0;
            o_rsp_valid   <= 1'b0;
            o_rsp_data    <= 32'h0;
            o_rsp_status  <= 32'h0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
            ctl_q         <= 32'h0;
            gap_cnt       <= '0;
            poll_cnt      <= '0;
        end else begin
            if (o_wb_stb && !i_wb_stall) o_wb_stb <= 1'b0;
            if (bus_done) begin
                o_wb_cyc <= 1'b0;
                o_wb_stb <= 1'b0;
            end
            if (launch) begin
                o_wb_cyc  <= 1'b1;
                o_wb_stb  <= 1'b1;
                o_wb_we   <= (state_nx == WR_ARG) || (state_nx == WR_CMD);
                o_wb_addr <= (state_nx == WR_ARG || state_nx == RD_RSP) ? ADDR_ARG : ADDR_CMD;
                o_wb_data <= (state_nx == WR_ARG) ? i_req_arg :
                             (state_nx == WR_CMD) ? ctl_q : 32'h0;
            end

            if (accept) begin
                ctl_q         <= i_req_ctl;
                o_rsp_data    <= 32'h0;
                o_rsp_status  <= 32'h0;
                o_rsp_err     <= 1'b0;
                o_rsp_timeout <= 1'b0;
            end

            gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;

            if (state == WR_CMD && bus_done) poll_cnt <= '0;
            if (state == RD_STAT && bus_done) begin
                poll_cnt     <= poll_cnt + LGPOLL'(1);
                o_rsp_status <= i_wb_data;
                if (stat_busy && poll_last) begin
                    o_rsp_timeout <= 1'b1;
                    o_rsp_err     <= 1'b1;
                end
            end
            if (state == RD_RSP && bus_done) begin
                o_rsp_data <= i_wb_data;
                o_rsp_err  <= |(o_rsp_status & ERR_MASK);
            end

            // valid rises one cycle after entering RESP and drops on handshake
            if (state == RESP && !o_rsp_valid) o_rsp_valid <= 1'b1;
            else if (o_rsp_valid && i_rsp_ready) o_rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdio_cmdseq.sv
// Directed bench for sdio_cmdseq with a Wishbone slave model and response/op scoreboards.
module tb_sdio_cmdseq;
    localparam int          POLL_GAP = 4;
    localparam int          LGPOLL   = 3;
    localparam logic [31:0] BUSY     = 32'h0000_4000;
    localparam logic [31:0] ERR      = 32'h0000_8000;
    localparam int          W        = 66;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [31:0] req_ctl = '0, req_arg = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_data, rsp_status;
    logic        rsp_err, rsp_timeout;
    logic        wb_cyc, wb_stb, wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_dout;
    logic [3:0]  wb_sel;
    logic        wb_stall = 1'b0, wb_ack = 1'b0;
    logic [31:0] wb_din = '0;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  exp_q[$];
    logic [35:0]   exp_op_q[$];
    logic [35:0]   obs_q[$];
    int            stamp_q[$];

    // slave model configuration (written only by the initial block)
    logic [31:0] final_status = '0, rsp_word = '0;
    int          busy_until = 0;
    logic        stall_en = 1'b0;
    // slave model state (written only by the slave process)
    int   stat_reads = 0, tick = 0, stb_drop_err = 0;
    logic prev_stall = 1'b0;

    always #5 clk = ~clk;

    sdio_cmdseq #(.LGPOLL(LGPOLL), .POLL_GAP(POLL_GAP)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_ctl(req_ctl), .i_req_arg(req_arg),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_data(rsp_data), .o_rsp_status(rsp_status),
        .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_data(wb_dout), .o_wb_sel(wb_sel),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_din),
        .dbg_state(dbg_state)
    );

    // Wishbone slave: ack one cycle after an accepted strobe, status busy until busy_until reads
    always @(posedge clk) begin
        tick       <= tick + 1;
        wb_ack     <= 1'b0;
        prev_stall <= wb_cyc && wb_stb && wb_stall;
        if (prev_stall && !(wb_cyc && wb_stb)) stb_drop_err <= stb_drop_err + 1;
        if (wb_cyc && wb_stb && !wb_stall) begin
            obs_q.push_back({wb_we, wb_addr, wb_we ? wb_dout : 32'h0});
            stamp_q.push_back(tick);
            wb_ack <= 1'b1;
            if (!wb_we && wb_addr == 3'd0) begin
                stat_reads <= stat_reads + 1;
                wb_din     <= (stat_reads < busy_until) ? BUSY : final_status;
            end else begin
                wb_din <= rsp_word;
            end
        end
        wb_stall <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] ctl, input logic [31:0] arg,
                           input int busy_polls, input logic [31:0] fstat,
                           input logic [31:0] rword, input int bp, input logic chk_lat);
        logic [W-1:0] e;
        logic [31:0]  d, s;
        logic         er, to, stable, timeout_exp;
        int           lat, n_reads, n;
        busy_until   = stat_reads + busy_polls;
        final_status = fstat;
        rsp_word     = rword;
        timeout_exp  = busy_polls >= (1 << LGPOLL);
        obs_q.delete();
        stamp_q.delete();
        exp_op_q.delete();
        exp_op_q.push_back({1'b1, 3'd1, arg});
        exp_op_q.push_back({1'b1, 3'd0, ctl});
        n_reads = timeout_exp ? (1 << LGPOLL) : busy_polls + 1;
        for (int i = 0; i < n_reads; i++) exp_op_q.push_back({1'b0, 3'd0, 32'h0});
        if (!timeout_exp) exp_op_q.push_back({1'b0, 3'd1, 32'h0});
        exp_q.push_back({timeout_exp, timeout_exp | (|(fstat & ERR)),
                         timeout_exp ? BUSY : fstat, timeout_exp ? 32'h0 : rword});

        @(negedge clk);
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        chk({tag, "_ready_before"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_ctl   = ctl;
        req_arg   = arg;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_ctl   = $urandom;
        req_arg   = $urandom;

        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 2000);
        chk({tag, "_valid_seen"}, rsp_valid, 1'b1);
        if (chk_lat) chk({tag, "_latency"}, lat, 13);

        d = rsp_data; s = rsp_status; er = rsp_err; to = rsp_timeout;
        stable = 1'b1;
        if (bp > 0) begin
            req_valid = 1'b1;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk);
                #1;
                if (!rsp_valid || req_ready || rsp_data !== d || rsp_status !== s ||
                    rsp_err !== er || rsp_timeout !== to) stable = 1'b0;
            end
            req_valid = 1'b0;
            chk({tag, "_bp_stable"}, stable, 1'b1);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, rsp_valid, 1'b0);
        chk({tag, "_ready_back"}, req_ready, 1'b1);

        e = exp_q.pop_front();
        chk({tag, "_timeout"}, to, e[65]);
        chk({tag, "_err"},     er, e[64]);
        chk({tag, "_status"},  s,  e[63:32]);
        chk({tag, "_data"},    d,  e[31:0]);

        chk({tag, "_op_count"}, obs_q.size(), exp_op_q.size());
        n = (obs_q.size() < exp_op_q.size()) ? obs_q.size() : exp_op_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_op%0d", tag, i), obs_q[i], exp_op_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;
        int   found;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_bus", {wb_cyc, wb_stb, wb_we, wb_addr}, 6'd0);
        chk("rst_wdata", wb_dout, 32'h0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'd0);
        chk("rst_rspdata", {rsp_data, rsp_status}, 64'h0);
        chk("sel", wb_sel, 4'hf);
        rst_n = 1'b1;

        // 1: reset while the command write strobe is out
        @(negedge clk);
        busy_until = stat_reads + 0;
        final_status = 32'h0;
        req_valid = 1'b1; req_ctl = 32'h0000_0800; req_arg = 32'h1111_2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (dbg_state == 3'd2 && wb_stb) found = 1;
        end
        chk("abort_reach_wrcmd", found, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        chk("abort_ready", req_ready, 1'b1);
        chk("abort_valid", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_valid = 1'b1;
        end
        chk("abort_no_rsp", seen_valid, 1'b0);
        chk("abort_idle", dbg_state, 3'd0);

        // 2: basic command, busy clear on first poll
        run_req("basic", 32'h0000_0800, 32'h1234_5678, 0, 32'h0, 32'hCAFE_0001, 0, 1'b1);

        // 3: busy for three polls, reads spaced by the poll gap
        run_req("poll", 32'h0000_0811, 32'h0000_0042, 3, 32'h0, 32'h0BAD_F00D, 0, 1'b0);
        for (int i = 3; i < 6 && i < stamp_q.size(); i++)
            chk($sformatf("poll_spacing%0d", i), stamp_q[i] - stamp_q[i-1], POLL_GAP + 2);

        // 4: busy stuck -> timeout after 2^LGPOLL reads
        run_req("timeout", 32'h0000_0C00, 32'hDEAD_BEEF, 100, 32'h0, 32'h5555_AAAA, 0, 1'b0);

        // 5: error status with random stall
        stall_en = 1'b1;
        run_req("errstall", 32'h0000_0D19, $urandom, 1, ERR, $urandom, 0, 1'b0);
        run_req("stall2", 32'h0000_0A01, $urandom, 2, 32'h0000_0001, $urandom, 0, 1'b0);
        stall_en = 1'b0;
        @(negedge clk);
        chk("stb_held_until_accept", stb_drop_err, 0);

        // 6: response backpressure for 20 cycles, then a fresh request
        run_req("bp", 32'h0000_0901, 32'hA5A5_0000, 1, 32'h0000_0003, 32'h7777_1234, 20, 1'b0);
        run_req("after_bp", 32'h0000_0800, 32'h0000_0001, 0, 32'h0, 32'h0000_FFFF, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
